// File: rtl/store_chk_pkg.sv
// Shared types for the store-stream checker: the checker's states, its two
// compare modes, the verdict cause codes and the (addr,data) table entry.
package store_chk_pkg;

   localparam int ST_ADDR_W = 32;
   localparam int ST_DATA_W = 32;

   typedef enum logic {SEQ = 1'b0, FINAL = 1'b1} mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      MISMATCH = 2'd1,
      TIMEOUT  = 2'd2,
      CFG      = 2'd3
   } fail_code_e;

   typedef struct packed {
      logic [ST_ADDR_W-1:0] addr;
      logic [ST_DATA_W-1:0] data;
   } store_t;

   // Exact store equality: both address and data must agree.
   function automatic logic store_eq(input store_t a, input store_t b);
      return (a.addr == b.addr) && (a.data == b.data);
   endfunction

endpackage

// File: rtl/store_chk_table.sv
// Expected-store table: DEPTH entries with one write port, two read ports
// (current sequence pointer and final entry) and an address-only hit vector
// over the non-final entries used by FINAL mode.
module store_chk_table
   import store_chk_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_widx,
   input  store_t                   i_wentry,
   input  logic [$clog2(DEPTH)-1:0] i_ptr,
   input  logic [$clog2(DEPTH)-1:0] i_last_idx,
   input  logic [$clog2(DEPTH):0]   i_len,
   input  logic [ST_ADDR_W-1:0]     i_probe_addr,
   output store_t                   o_ptr_entry,
   output store_t                   o_last_entry,
   output logic [DEPTH-1:0]         o_hit
);

   store_t r_tbl [DEPTH];

   // Single write port; contents survive reset so a table loaded once can be re-armed.
   always_ff @(posedge clk) begin
      if (i_we && (int'(i_widx) < DEPTH)) begin
         r_tbl[i_widx] <= i_wentry;
      end
   end

   assign o_ptr_entry  = r_tbl[i_ptr];
   assign o_last_entry = r_tbl[i_last_idx];

   // Address hit against entries 0..len-2 only; the final entry needs an exact match.
   always_comb begin
      o_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_hit[i] = ((i + 1) < int'(i_len)) && (r_tbl[i].addr == i_probe_addr);
      end
   end

endmodule

// File: rtl/store_stream_checker.sv
// Store-bus checker: watches the core's data-memory write strobe while armed
// and compares each store with a loadable expected table, producing a sticky
// pass/fail verdict with a cause code and the offending store on mismatch.
module store_stream_checker
   import store_chk_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 10000,
   parameter int MODE    = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_write,
   input  logic [ADDR_W-1:0]        data_adr,
   input  logic [DATA_W-1:0]        write_data,
   input  logic                     tbl_we,
   input  logic [$clog2(DEPTH)-1:0] tbl_idx,
   input  logic [ADDR_W-1:0]        tbl_addr,
   input  logic [DATA_W-1:0]        tbl_data,
   input  logic [$clog2(DEPTH):0]   tbl_len,
   input  logic                     arm,
   output logic                     busy,
   output logic                     pass,
   output logic                     fail,
   output logic [1:0]               fail_code,
   output logic [$clog2(DEPTH):0]   match_cnt,
   output logic [ADDR_W-1:0]        fail_addr,
   output logic [DATA_W-1:0]        fail_data
);

   localparam int    IW = $clog2(DEPTH);
   localparam int    LW = IW + 1;
   localparam mode_e M  = (MODE == 1) ? FINAL : SEQ;

   state_e      r_state,     w_state_nxt;
   logic [IW-1:0] r_ptr,     w_ptr_nxt;
   logic [LW-1:0] r_len,     w_len_nxt;
   logic [LW-1:0] r_match,   w_match_nxt;
   logic [31:0] r_cnt,       w_cnt_nxt;
   fail_code_e  r_code,      w_code_nxt;
   logic [ADDR_W-1:0] r_fail_addr, w_faddr_nxt;
   logic [DATA_W-1:0] r_fail_data, w_fdata_nxt;

   logic          w_we;
   logic [IW-1:0] w_last_idx;
   store_t        w_probe;
   store_t        w_wentry;
   store_t        w_ptr_entry;
   store_t        w_last_entry;
   logic [DEPTH-1:0] w_hit;
   logic          w_ok;
   logic          w_done;

   // The table is frozen while a run is in progress.
   assign w_we       = tbl_we && (r_state != RUN);
   assign w_last_idx = IW'(r_len - LW'(1));

   assign w_probe.addr  = ST_ADDR_W'(data_adr);
   assign w_probe.data  = ST_DATA_W'(write_data);
   assign w_wentry.addr = ST_ADDR_W'(tbl_addr);
   assign w_wentry.data = ST_DATA_W'(tbl_data);

   store_chk_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .clk          (clk),
      .i_we         (w_we),
      .i_widx       (tbl_idx),
      .i_wentry     (w_wentry),
      .i_ptr        (r_ptr),
      .i_last_idx   (w_last_idx),
      .i_len        (r_len),
      .i_probe_addr (w_probe.addr),
      .o_ptr_entry  (w_ptr_entry),
      .o_last_entry (w_last_entry),
      .o_hit        (w_hit)
   );

   // Next-state logic: judge the sampled store (accepted / finishing / rejected), else check timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_len_nxt   = r_len;
      w_match_nxt = r_match;
      w_cnt_nxt   = r_cnt;
      w_code_nxt  = r_code;
      w_faddr_nxt = r_fail_addr;
      w_fdata_nxt = r_fail_data;
      w_ok        = 1'b0;
      w_done      = 1'b0;

      if (M == SEQ) begin
         w_ok   = store_eq(w_probe, w_ptr_entry);
         w_done = (r_ptr == w_last_idx);
      end else begin
         w_ok   = store_eq(w_probe, w_last_entry) || (|w_hit);
         w_done = store_eq(w_probe, w_last_entry);
      end

      case (r_state)
         RUN: begin
            w_cnt_nxt = r_cnt + 32'd1;
            if (mem_write) begin
               if (w_ok) begin
                  if (r_match != {LW{1'b1}}) begin
                     w_match_nxt = r_match + LW'(1);
                  end
                  if (M == SEQ) begin
                     w_ptr_nxt = r_ptr + IW'(1);
                  end
                  if (w_done) begin
                     w_state_nxt = PASS;
                  end
               end else begin
                  w_state_nxt = FAIL;
                  w_code_nxt  = MISMATCH;
                  w_faddr_nxt = data_adr;
                  w_fdata_nxt = write_data;
               end
            end else if ((TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1))) begin
               w_state_nxt = FAIL;
               w_code_nxt  = store_chk_pkg::TIMEOUT;
            end
         end
         default: begin
            if (arm) begin
               w_len_nxt   = tbl_len;
               w_ptr_nxt   = '0;
               w_match_nxt = '0;
               w_cnt_nxt   = '0;
               w_code_nxt  = NONE;
               w_faddr_nxt = '0;
               w_fdata_nxt = '0;
               if ((tbl_len == '0) || (int'(tbl_len) > DEPTH)) begin
                  w_state_nxt = FAIL;
                  w_code_nxt  = CFG;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
      endcase
   end

   // State and run registers; reset aborts any run and clears every visible field.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_len       <= '0;
         r_match     <= '0;
         r_cnt       <= '0;
         r_code      <= NONE;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_len       <= w_len_nxt;
         r_match     <= w_match_nxt;
         r_cnt       <= w_cnt_nxt;
         r_code      <= w_code_nxt;
         r_fail_addr <= w_faddr_nxt;
         r_fail_data <= w_fdata_nxt;
      end
   end

   assign busy      = (r_state == RUN);
   assign pass      = (r_state == PASS);
   assign fail      = (r_state == FAIL);
   assign fail_code = r_code;
   assign match_cnt = r_match;
   assign fail_addr = r_fail_addr;
   assign fail_data = r_fail_data;

endmodule
